// File: rtl/iwb_lsu_wb_stage.sv
// Registered write-back stage: selects the write-back source, waits for load
// responses with a timeout watchdog, formats load data and drives the RF port.
module iwb_lsu_wb_stage #(
    parameter int WIDTH       = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_iwb_valid,
    output logic                  o_iwb_ready,
    input  logic                  i_iwb_rf_wen,
    input  logic [REG_ADDR_W-1:0] i_iwb_rd,
    input  logic [2:0]            i_iwb_rf_wb_src_ctrl,
    input  logic [WIDTH-1:0]      i_iwb_alu_out,
    input  logic [WIDTH-1:0]      i_iwb_sx_data,
    input  logic [WIDTH-1:0]      i_iwb_pc_plus_4,
    input  logic [WIDTH-1:0]      i_iwb_bu_next_dest_jb,
    input  logic [2:0]            i_iwb_ld_funct3,
    input  logic [1:0]            i_iwb_ld_addr_lo,
    input  logic                  i_iwb_mem_rvalid,
    input  logic [WIDTH-1:0]      i_iwb_r_mem,
    output logic                  o_iwb_rf_we,
    output logic [REG_ADDR_W-1:0] o_iwb_rf_rd,
    output logic [WIDTH-1:0]      o_iwb_wb_data,
    output logic                  o_iwb_stall,
    output logic                  o_iwb_misaligned,
    output logic                  o_iwb_ld_timeout
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0] SRC_ALU = 3'b000;
    localparam logic [2:0] SRC_MEM = 3'b001;
    localparam logic [2:0] SRC_PC4 = 3'b010;
    localparam logic [2:0] SRC_IMM = 3'b011;
    localparam logic [2:0] SRC_JB  = 3'b100;

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t                  state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic                    ld_wen_r, ld_wen_s;
    logic [REG_ADDR_W-1:0]   ld_rd_r, ld_rd_s;
    logic [2:0]              ld_funct3_r, ld_funct3_s;
    logic [1:0]              ld_addr_lo_r, ld_addr_lo_s;
    logic                    rf_we_r, rf_we_s;
    logic [REG_ADDR_W-1:0]   rf_rd_r, rf_rd_s;
    logic [WIDTH-1:0]        wb_data_r, wb_data_s;
    logic                    misaligned_r, misaligned_s;
    logic                    ld_timeout_r, ld_timeout_s;
    logic [WIDTH-1:0]        sel_data_s;

    function automatic logic [WIDTH-1:0] fmt_load(input logic [2:0] funct3,
                                                  input logic [1:0] addr_lo,
                                                  input logic [WIDTH-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  fmt_load = {{(WIDTH-8){b[7]}}, b};
            3'b001:  fmt_load = {{(WIDTH-16){h[15]}}, h};
            3'b010:  fmt_load = word;
            3'b100:  fmt_load = {{(WIDTH-8){1'b0}}, b};
            3'b101:  fmt_load = {{(WIDTH-16){1'b0}}, h};
            default: fmt_load = '0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            3'b001, 3'b101: is_misaligned = addr_lo[0];
            3'b010:         is_misaligned = (addr_lo != 2'b00);
            default:        is_misaligned = 1'b0;
        endcase
    endfunction

    // Non-load write-back source mux
    always_comb begin
        case (i_iwb_rf_wb_src_ctrl)
            SRC_ALU: sel_data_s = i_iwb_alu_out;
            SRC_PC4: sel_data_s = i_iwb_pc_plus_4;
            SRC_IMM: sel_data_s = i_iwb_sx_data;
            SRC_JB:  sel_data_s = i_iwb_bu_next_dest_jb;
            default: sel_data_s = '0;
        endcase
    end

    // Next-state and next-output logic; rd/data only update alongside a write
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        ld_wen_s     = ld_wen_r;
        ld_rd_s      = ld_rd_r;
        ld_funct3_s  = ld_funct3_r;
        ld_addr_lo_s = ld_addr_lo_r;
        rf_we_s      = 1'b0;
        rf_rd_s      = rf_rd_r;
        wb_data_s    = wb_data_r;
        misaligned_s = 1'b0;
        ld_timeout_s = ld_timeout_r;
        case (state_r)
            IDLE: begin
                if (i_iwb_valid && (i_iwb_rf_wb_src_ctrl == SRC_MEM)) begin
                    if (is_misaligned(i_iwb_ld_funct3, i_iwb_ld_addr_lo)) begin
                        misaligned_s = 1'b1;
                    end else begin
                        ld_wen_s     = i_iwb_rf_wen;
                        ld_rd_s      = i_iwb_rd;
                        ld_funct3_s  = i_iwb_ld_funct3;
                        ld_addr_lo_s = i_iwb_ld_addr_lo;
                        cnt_s        = '0;
                        state_s      = WAIT_MEM;
                    end
                end else if (i_iwb_valid && i_iwb_rf_wen && (i_iwb_rd != '0)) begin
                    rf_we_s   = 1'b1;
                    rf_rd_s   = i_iwb_rd;
                    wb_data_s = sel_data_s;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_MEM: begin
                if (i_iwb_mem_rvalid) begin
                    if (ld_wen_r && (ld_rd_r != '0)) begin
                        rf_we_s   = 1'b1;
                        rf_rd_s   = ld_rd_r;
                        wb_data_s = fmt_load(ld_funct3_r, ld_addr_lo_r, i_iwb_r_mem);
                    end else begin
                        rf_we_s = 1'b0;
                    end
                    state_s = IDLE;
                end else if (cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
                    ld_timeout_s = 1'b1;
                    state_s      = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, load context and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            ld_wen_r     <= 1'b0;
            ld_rd_r      <= '0;
            ld_funct3_r  <= 3'b000;
            ld_addr_lo_r <= 2'b00;
            rf_we_r      <= 1'b0;
            rf_rd_r      <= '0;
            wb_data_r    <= '0;
            misaligned_r <= 1'b0;
            ld_timeout_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            ld_wen_r     <= ld_wen_s;
            ld_rd_r      <= ld_rd_s;
            ld_funct3_r  <= ld_funct3_s;
            ld_addr_lo_r <= ld_addr_lo_s;
            rf_we_r      <= rf_we_s;
            rf_rd_r      <= rf_rd_s;
            wb_data_r    <= wb_data_s;
            misaligned_r <= misaligned_s;
            ld_timeout_r <= ld_timeout_s;
        end
    end

    assign o_iwb_ready      = (state_r == IDLE);
    assign o_iwb_stall      = (state_r != IDLE);
    assign o_iwb_rf_we      = rf_we_r;
    assign o_iwb_rf_rd      = rf_rd_r;
    assign o_iwb_wb_data    = wb_data_r;
    assign o_iwb_misaligned = misaligned_r;
    assign o_iwb_ld_timeout = ld_timeout_r;

endmodule
